// File: rtl/lcd_scanout.sv
// lcd_scanout: raster timing generator and line-buffer reader for an RGB LCD panel.
// Counter state drives the RAM address; all panel outputs are registered two clocks later.
module lcd_scanout #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 48,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 13,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 32,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [9:0]  rd_addr,
  output logic        rd_ce,
  input  logic [23:0] rd_data,
  output logic        line_req,
  output logic [9:0]  line_num,
  input  logic        line_ready,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [23:0] lcd_rgb,
  output logic        frame_start,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d, next_v;
  logic          ready_q, ready_d, ok_q, ok_d;
  logic          req_q, req_d;
  logic [9:0]    num_q, num_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic          fs1_q, fs1_d, ur1_q, ur1_d, ok1_q, ok1_d;
  logic          de_q, hs_q, vs_q, fs_q, ur_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          h_wrap, active, line_start, req_fire, ur_start;

  always_comb begin
    h_wrap     = h_q == H_LAST;
    next_v     = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    h_d        = h_wrap ? '0 : h_q + 1'b1;
    v_d        = h_wrap ? next_v : v_q;
    active     = (h_q < H_ACT) && (v_q < V_ACT);
    line_start = (h_q == '0) && (v_q < V_ACT);
    req_fire   = (h_q == H_ACT) && (next_v < V_ACT);
    req_d      = req_fire;
    num_d      = req_fire ? 10'(next_v) : num_q;
    // Clearing on the visible request pulse lets a coincident line_ready lose.
    ready_d    = req_q ? 1'b0 : (line_ready ? 1'b1 : ready_q);
    ok_d       = line_start ? ready_q : ok_q;
    ur_start   = line_start && !ready_q;
    cnt_d      = (ur_start && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    de1_d      = active;
    hs1_d      = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs1_d      = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
    fs1_d      = line_start && (v_q == '0);
    ur1_d      = ur_start;
    ok1_d      = ok_d;
    rgb_d      = (de1_q && ok1_q) ? rd_data : '0;
    rd_ce      = active;
    rd_addr    = active ? 10'(h_q) : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q     <= '0;
      v_q     <= V_ACT;
      ready_q <= 1'b0;
      ok_q    <= 1'b0;
      req_q   <= 1'b0;
      num_q   <= '0;
      cnt_q   <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= ~HS_POL;
      vs1_q   <= ~VS_POL;
      fs1_q   <= 1'b0;
      ur1_q   <= 1'b0;
      ok1_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      ready_q <= ready_d;
      ok_q    <= ok_d;
      req_q   <= req_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      ur1_q   <= ur1_d;
      ok1_q   <= ok1_d;
      de_q    <= de1_q;
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
      fs_q    <= fs1_q;
      ur_q    <= ur1_q;
      rgb_q   <= rgb_d;
    end
  end

  assign line_req     = req_q;
  assign line_num     = num_q;
  assign underrun_cnt = cnt_q;
  assign lcd_de       = de_q;
  assign lcd_hsync    = hs_q;
  assign lcd_vsync    = vs_q;
  assign lcd_rgb      = rgb_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;
endmodule

// File: tb/tb_lcd_scanout.sv
// tb_lcd_scanout: directed bench for lcd_scanout with reduced 14x7 raster timing.
// Cycle n is the state after n rising edges since reset release; sampling is on the falling edge.
module tb_lcd_scanout;
  logic        clk = 1'b0, resetn = 1'b0, line_ready = 1'b0;
  logic        rd_ce, line_req, lcd_de, lcd_hsync, lcd_vsync, frame_start, underrun;
  logic [9:0]  rd_addr, line_num;
  logic [23:0] rd_data = 24'h0, lcd_rgb;
  logic [7:0]  underrun_cnt;
  int          checks = 0, errors = 0, cyc = 0, skip_line = -1;
  logic        pend = 1'b0, respond = 1'b1, coll = 1'b0;

  lcd_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_ce(rd_ce), .rd_data(rd_data),
    .line_req(line_req), .line_num(line_num), .line_ready(line_ready),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_rgb(lcd_rgb),
    .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_ce) rd_data <= 24'h0A0B00 + {14'd0, rd_addr};

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Upstream model: answers a request one cycle later, or in the same cycle when coll is set.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    line_ready = pend;
    pend = 1'b0;
    if (line_req) begin
      if (coll) line_ready = 1'b1;
      else if (respond && int'(line_num) != skip_line) pend = 1'b1;
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    cyc = 0;
    pend = 1'b0;
    line_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hsync", 32'(lcd_hsync), 1);
    chk("rst_vsync", 32'(lcd_vsync), 1);
    chk("rst_de", 32'(lcd_de), 0);
    chk("rst_rgb", 32'(lcd_rgb), 0);
    chk("rst_cnt", 32'(underrun_cnt), 0);
    chk("rst_req", 32'(line_req), 0);
    chk("rst_ce", 32'(rd_ce), 0);
    chk("rst_fs_ur", {30'd0, frame_start, underrun}, 0);
    release_reset();
    skip_line = 2;
    run_to(15); chk("vs_before", 32'(lcd_vsync), 1);
    run_to(16); chk("vs_low_first", 32'(lcd_vsync), 0);
    run_to(29); chk("vs_low_last", 32'(lcd_vsync), 0);
    run_to(30); chk("vs_after", 32'(lcd_vsync), 1);
    run_to(36); chk("req_early", 32'(line_req), 0);
    run_to(37); chk("req_first", 32'(line_req), 1); chk("req_num0", 32'(line_num), 0);
    run_to(38); chk("req_pulse", 32'(line_req), 0);
    run_to(43); chk("de_before", 32'(lcd_de), 0);
    chk("rd_ce_act", 32'(rd_ce), 1); chk("rd_addr_act", 32'(rd_addr), 1);
    run_to(44);
    chk("de_first", 32'(lcd_de), 1); chk("fs_first", 32'(frame_start), 1);
    chk("rgb_px0", 32'(lcd_rgb), 32'h0A0B00); chk("ur_l0", 32'(underrun), 0);
    run_to(45); chk("fs_pulse", 32'(frame_start), 0); chk("rgb_px1", 32'(lcd_rgb), 32'h0A0B01);
    run_to(50); chk("rd_ce_blank", 32'(rd_ce), 0); chk("rd_addr_blank", 32'(rd_addr), 0);
    run_to(51); chk("rgb_px7", 32'(lcd_rgb), 32'h0A0B07); chk("de_last", 32'(lcd_de), 1);
    run_to(52); chk("de_fall", 32'(lcd_de), 0);
    run_to(53); chk("hs_before", 32'(lcd_hsync), 1);
    run_to(54); chk("hs_low0", 32'(lcd_hsync), 0);
    run_to(55); chk("hs_low1", 32'(lcd_hsync), 0);
    run_to(56); chk("hs_after", 32'(lcd_hsync), 1);
    run_to(58); chk("l1_rgb0", 32'(lcd_rgb), 32'h0A0B00);
    run_to(65); chk("req_l2", 32'(line_req), 1); chk("req_num2", 32'(line_num), 2);
    run_to(72);
    chk("ur_l2", 32'(underrun), 1); chk("ur_l2_de", 32'(lcd_de), 1); chk("ur_l2_rgb0", 32'(lcd_rgb), 0);
    run_to(73); chk("ur_pulse", 32'(underrun), 0);
    run_to(79); chk("ur_l2_rgb7", 32'(lcd_rgb), 0); chk("ur_l2_de7", 32'(lcd_de), 1);
    run_to(80); chk("cnt_1", 32'(underrun_cnt), 1);
    run_to(86); chk("l3_rgb0", 32'(lcd_rgb), 32'h0A0B00); chk("l3_ur", 32'(underrun), 0);
    run_to(93); chk("l3_rgb7", 32'(lcd_rgb), 32'h0A0B07);
    run_to(100);
    skip_line = -1;
    coll = 1'b1;
    run_to(135); chk("coll_req", 32'(line_req), 1); chk("coll_ready", 32'(line_ready), 1);
    run_to(136);
    coll = 1'b0;
    run_to(142);
    chk("coll_ur", 32'(underrun), 1); chk("coll_fs", 32'(frame_start), 1); chk("coll_rgb", 32'(lcd_rgb), 0);
    run_to(150); chk("cnt_2", 32'(underrun_cnt), 2);
    run_to(156); chk("f2l1_rgb0", 32'(lcd_rgb), 32'h0A0B00); chk("f2l1_ur", 32'(underrun), 0);
    run_to(160);
    respond = 1'b0;
    run_to(7880); chk("cnt_sat", 32'(underrun_cnt), 255);
    run_to(7884);
    chk("sat_ur", 32'(underrun), 1); chk("sat_rgb", 32'(lcd_rgb), 0);
    chk("sat_de", 32'(lcd_de), 1); chk("sat_cnt", 32'(underrun_cnt), 255);
    run_to(7886);
    resetn = 1'b0;
    #1;
    chk("mid_de", 32'(lcd_de), 0); chk("mid_rgb", 32'(lcd_rgb), 0);
    chk("mid_cnt", 32'(underrun_cnt), 0); chk("mid_vsync", 32'(lcd_vsync), 1);
    chk("mid_hsync", 32'(lcd_hsync), 1); chk("mid_ce", 32'(rd_ce), 0);
    respond = 1'b1;
    release_reset();
    run_to(36); chk("re_req_early", 32'(line_req), 0);
    run_to(37); chk("re_req", 32'(line_req), 1); chk("re_num", 32'(line_num), 0);
    run_to(44);
    chk("re_de", 32'(lcd_de), 1); chk("re_fs", 32'(frame_start), 1);
    chk("re_rgb", 32'(lcd_rgb), 32'h0A0B00); chk("re_ur", 32'(underrun), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
